// File: rtl/evg_event_arbiter_if.sv
// Event source streams into the EVG slot arbiter and the registered granted-event bus out of it.
// The master side drives the sources and observes the granted event; the slave side is the arbiter.
interface evg_event_arbiter_if #(
    parameter int EVENTCODE_WIDTH = 8
);
    logic [EVENTCODE_WIDTH-1:0] seq_tdata;
    logic                       seq_tvalid;
    logic [EVENTCODE_WIDTH-1:0] hw_tdata;
    logic                       hw_tvalid;
    logic                       hw_tready;
    logic [EVENTCODE_WIDTH-1:0] sw_tdata;
    logic                       sw_tvalid;
    logic                       sw_tready;
    logic [EVENTCODE_WIDTH-1:0] ev_code;
    logic                       ev_valid;
    logic [1:0]                 ev_source;

    modport master (
        output seq_tdata, seq_tvalid, hw_tdata, hw_tvalid, sw_tdata, sw_tvalid,
        input  hw_tready, sw_tready, ev_code, ev_valid, ev_source
    );

    modport slave (
        input  seq_tdata, seq_tvalid, hw_tdata, hw_tvalid, sw_tdata, sw_tvalid,
        output hw_tready, sw_tready, ev_code, ev_valid, ev_source
    );
endinterface

// File: rtl/evg_event_arbiter.sv
// One event slot per cycle: sequencer > pending heartbeat > hw/sw round-robin; output 1 cycle after grant.
// Sequencer has no backpressure; hw/sw TREADY comes combinationally from the current-cycle grant.
module evg_event_arbiter #(
    parameter int                         EVENTCODE_WIDTH = 8,
    parameter logic [EVENTCODE_WIDTH-1:0] HEARTBEAT_CODE  = 'h7A,
    parameter int                         STAT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            source_enable_i,
    input  logic                  clear_stats_i,
    input  logic                  heartbeat_req_i,
    evg_event_arbiter_if.slave    ev_if,
    output logic [STAT_WIDTH-1:0] heartbeat_lost_count_o,
    output logic [STAT_WIDTH-1:0] hardware_wait_max_o
);
    localparam logic [1:0] SRC_SEQ = 2'd0;
    localparam logic [1:0] SRC_HB  = 2'd1;
    localparam logic [1:0] SRC_HW  = 2'd2;
    localparam logic [1:0] SRC_SW  = 2'd3;

    logic [EVENTCODE_WIDTH-1:0] code_q, code_d;
    logic                       valid_q, valid_d;
    logic [1:0]                 src_q, src_d;
    logic                       hb_pend_q, hb_pend_d;
    logic                       last_hw_q, last_hw_d;
    logic [STAT_WIDTH-1:0]      lost_q, lost_d;
    logic [STAT_WIDTH-1:0]      wait_q, wait_d;
    logic [STAT_WIDTH-1:0]      wait_max_q, wait_max_d;

    logic seq_grant, hb_grant, slot_free;
    logic hw_req, sw_req, hw_slot, sw_slot, hw_grant, sw_grant;
    logic hw_xfer, lost_inc;

    // hw_slot/sw_slot only look at the *other* stream's valid, so a TREADY never depends on its own TVALID.
    always_comb begin
        seq_grant = ev_if.seq_tvalid & source_enable_i[0];
        hb_grant  = ~seq_grant & hb_pend_q & source_enable_i[1];
        slot_free = ~seq_grant & ~hb_grant;
        hw_req    = ev_if.hw_tvalid & source_enable_i[2];
        sw_req    = ev_if.sw_tvalid & source_enable_i[3];
        hw_slot   = slot_free & (~sw_req | ~last_hw_q);
        sw_slot   = slot_free & (~hw_req | last_hw_q);
        hw_grant  = hw_req & hw_slot;
        sw_grant  = sw_req & sw_slot;
    end

    // A disabled stream is drained: always ready, accepted and dropped.
    assign ev_if.hw_tready = ~rst & (~source_enable_i[2] | hw_slot);
    assign ev_if.sw_tready = ~rst & (~source_enable_i[3] | sw_slot);
    assign hw_xfer         = ev_if.hw_tvalid & ev_if.hw_tready;

    always_comb begin
        code_d    = '0;
        valid_d   = 1'b0;
        src_d     = SRC_SEQ;
        last_hw_d = last_hw_q;
        if (seq_grant) begin
            code_d  = ev_if.seq_tdata;
            valid_d = 1'b1;
            src_d   = SRC_SEQ;
        end else if (hb_grant) begin
            code_d  = HEARTBEAT_CODE;
            valid_d = 1'b1;
            src_d   = SRC_HB;
        end else if (hw_grant) begin
            code_d    = ev_if.hw_tdata;
            valid_d   = 1'b1;
            src_d     = SRC_HW;
            last_hw_d = 1'b1;
        end else if (sw_grant) begin
            code_d    = ev_if.sw_tdata;
            valid_d   = 1'b1;
            src_d     = SRC_SW;
            last_hw_d = 1'b0;
        end
    end

    // A request arriving while the flag is being served re-arms it rather than counting as lost.
    always_comb begin
        hb_pend_d = hb_pend_q & ~hb_grant;
        lost_inc  = 1'b0;
        if (!source_enable_i[1]) begin
            hb_pend_d = 1'b0;
        end else if (heartbeat_req_i) begin
            lost_inc  = hb_pend_q & ~hb_grant;
            hb_pend_d = 1'b1;
        end
    end

    always_comb begin
        lost_d     = lost_q;
        wait_d     = wait_q;
        wait_max_d = (wait_q > wait_max_q) ? wait_q : wait_max_q;
        if (lost_inc && lost_q != '1) begin
            lost_d = lost_q + 1'b1;
        end
        if (hw_xfer) begin
            wait_d = '0;
        end else if (ev_if.hw_tvalid && wait_q != '1) begin
            wait_d = wait_q + 1'b1;
        end
        if (clear_stats_i) begin
            lost_d     = '0;
            wait_d     = '0;
            wait_max_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q     <= '0;
            valid_q    <= 1'b0;
            src_q      <= SRC_SEQ;
            hb_pend_q  <= 1'b0;
            last_hw_q  <= 1'b0;
            lost_q     <= '0;
            wait_q     <= '0;
            wait_max_q <= '0;
        end else begin
            code_q     <= code_d;
            valid_q    <= valid_d;
            src_q      <= src_d;
            hb_pend_q  <= hb_pend_d;
            last_hw_q  <= last_hw_d;
            lost_q     <= lost_d;
            wait_q     <= wait_d;
            wait_max_q <= wait_max_d;
        end
    end

    assign ev_if.ev_code          = code_q;
    assign ev_if.ev_valid         = valid_q;
    assign ev_if.ev_source        = src_q;
    assign heartbeat_lost_count_o = lost_q;
    assign hardware_wait_max_o    = wait_max_q;
endmodule

// File: tb/tb_evg_event_arbiter.sv
// Scenario bench for evg_event_arbiter: expected {source, code} pairs are queued as stimulus is driven
// and popped by a monitor whenever the arbiter presents a valid event.
module tb_evg_event_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  en  = 4'h0;
    logic        clr = 1'b0;
    logic        hb  = 1'b0;
    logic [15:0] lost_cnt;
    logic [15:0] wait_max;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [9:0]  sb[$];

    evg_event_arbiter_if #(.EVENTCODE_WIDTH(8)) bus ();

    evg_event_arbiter #(
        .EVENTCODE_WIDTH(8),
        .HEARTBEAT_CODE (8'h7A),
        .STAT_WIDTH     (16)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .source_enable_i       (en),
        .clear_stats_i         (clr),
        .heartbeat_req_i       (hb),
        .ev_if                 (bus),
        .heartbeat_lost_count_o(lost_cnt),
        .hardware_wait_max_o   (wait_max)
    );

    always #5 clk = ~clk;

    // Outputs change on posedge only, so sampling on negedge is race-free.
    always @(negedge clk) begin
        logic [9:0] exp_v;
        if (!rst && bus.ev_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: got src=%0d code=%02h, required no event",
                         bus.ev_source, bus.ev_code);
            end else begin
                exp_v = sb.pop_front();
                if ({bus.ev_source, bus.ev_code} !== exp_v) begin
                    n_err++;
                    $display("FAIL event_order: got src=%0d code=%02h, required src=%0d code=%02h",
                             bus.ev_source, bus.ev_code, exp_v[9:8], exp_v[7:0]);
                end
            end
        end
    end

    // One cycle: let the combinational ready settle, then drop any accepted hw/sw beat and one-shot pulses.
    task automatic tick();
        logic hw_acc, sw_acc;
        #1;
        hw_acc = bus.hw_tvalid & bus.hw_tready;
        sw_acc = bus.sw_tvalid & bus.sw_tready;
        @(negedge clk);
        if (hw_acc) bus.hw_tvalid = 1'b0;
        if (sw_acc) bus.sw_tvalid = 1'b0;
        hb  = 1'b0;
        clr = 1'b0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        en             = 4'h0;
        hb             = 1'b0;
        clr            = 1'b0;
        bus.seq_tvalid = 1'b0;
        bus.hw_tvalid  = 1'b0;
        bus.sw_tvalid  = 1'b0;
        bus.seq_tdata  = 8'h00;
        bus.hw_tdata   = 8'h00;
        bus.sw_tdata   = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_sb_empty(input string name);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d events still expected, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst           = 1'b1;
        en            = 4'hF;
        bus.hw_tvalid = 1'b1;
        bus.hw_tdata  = 8'h55;
        bus.sw_tvalid = 1'b1;
        bus.sw_tdata  = 8'h00;
        #1;
        n_cmp++; if (bus.hw_tready !== 1'b0) begin n_err++; $display("FAIL reset_hw_tready: got %b, required 0", bus.hw_tready); end
        n_cmp++; if (bus.sw_tready !== 1'b0) begin n_err++; $display("FAIL reset_sw_tready: got %b, required 0", bus.sw_tready); end
        n_cmp++; if (bus.ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", bus.ev_valid); end
        n_cmp++; if (bus.ev_code !== 8'h00) begin n_err++; $display("FAIL reset_code: got %02h, required 00", bus.ev_code); end
        n_cmp++; if (lost_cnt !== 16'h0 || wait_max !== 16'h0) begin n_err++; $display("FAIL reset_stats: got lost=%0d wait=%0d, required 0 0", lost_cnt, wait_max); end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back({2'd2, 8'h55});
        sb.push_back({2'd3, 8'h00});
        tick();
        n_cmp++;
        if (bus.ev_valid !== 1'b1 || bus.ev_code !== 8'h55) begin
            n_err++;
            $display("FAIL first_latency: got valid=%b code=%02h, required valid=1 code=55", bus.ev_valid, bus.ev_code);
        end
        repeat (3) tick();
        test_sb_empty("reset");
    endtask

    task automatic test_priority();
        do_reset();
        en             = 4'hF;
        bus.seq_tvalid = 1'b1; bus.seq_tdata = 8'h10;
        bus.hw_tvalid  = 1'b1; bus.hw_tdata  = 8'h21;
        bus.sw_tvalid  = 1'b1; bus.sw_tdata  = 8'h31;
        sb.push_back({2'd0, 8'h10});
        sb.push_back({2'd2, 8'h21});
        sb.push_back({2'd3, 8'h31});
        #1;
        n_cmp++; if (bus.hw_tready !== 1'b0) begin n_err++; $display("FAIL seq_blocks_hw: got tready=%b, required 0", bus.hw_tready); end
        tick();
        bus.seq_tvalid = 1'b0;
        repeat (4) tick();
        test_sb_empty("priority");
    endtask

    task automatic test_heartbeat();
        do_reset();
        en = 4'hF;
        for (int i = 1; i <= 5; i++) begin
            bus.seq_tvalid = 1'b1;
            bus.seq_tdata  = 8'(i);
            hb             = (i == 1 || i == 3);
            sb.push_back({2'd0, 8'(i)});
            tick();
        end
        bus.seq_tvalid = 1'b0;
        hb = 1'b1;
        sb.push_back({2'd1, 8'h7A});
        tick();
        sb.push_back({2'd1, 8'h7A});
        repeat (3) tick();
        n_cmp++; if (lost_cnt !== 16'd1) begin n_err++; $display("FAIL hb_lost: got %0d, required 1", lost_cnt); end
        test_sb_empty("heartbeat");
    endtask

    task automatic test_round_robin();
        logic [7:0] hc, sc;
        do_reset();
        en = 4'hF;
        hc = 8'h60; sc = 8'h70;
        bus.hw_tvalid = 1'b1; bus.hw_tdata = hc;
        bus.sw_tvalid = 1'b1; bus.sw_tdata = sc;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) sb.push_back({2'd2, 8'h60 + 8'(i / 2)});
            else            sb.push_back({2'd3, 8'h70 + 8'(i / 2)});
            #1;
            n_cmp++;
            if (bus.hw_tready !== (i % 2 == 0)) begin
                n_err++;
                $display("FAIL rr_hw_tready_%0d: got %b, required %b", i, bus.hw_tready, (i % 2 == 0));
            end
            tick();
            if (!bus.hw_tvalid) begin hc++; bus.hw_tdata = hc; bus.hw_tvalid = 1'b1; end
            if (!bus.sw_tvalid) begin sc++; bus.sw_tdata = sc; bus.sw_tvalid = 1'b1; end
        end
        bus.hw_tvalid = 1'b0;
        bus.sw_tvalid = 1'b0;
        repeat (2) tick();
        test_sb_empty("round_robin");
    endtask

    task automatic test_stats();
        do_reset();
        en = 4'hF;
        bus.hw_tvalid = 1'b1; bus.hw_tdata = 8'h90;
        for (int i = 0; i < 7; i++) begin
            bus.seq_tvalid = 1'b1;
            bus.seq_tdata  = 8'h80 + 8'(i);
            sb.push_back({2'd0, 8'h80 + 8'(i)});
            tick();
        end
        bus.seq_tvalid = 1'b0;
        sb.push_back({2'd2, 8'h90});
        repeat (4) tick();
        n_cmp++; if (wait_max !== 16'd7) begin n_err++; $display("FAIL wait_max: got %0d, required 7", wait_max); end
        clr = 1'b1;
        tick();
        n_cmp++; if (wait_max !== 16'd0) begin n_err++; $display("FAIL wait_clear: got %0d, required 0", wait_max); end
        bus.seq_tvalid = 1'b1;
        bus.seq_tdata  = 8'h33;
        for (int i = 0; i < 65538; i++) begin
            hb = 1'b1;
            sb.push_back({2'd0, 8'h33});
            tick();
        end
        n_cmp++; if (lost_cnt !== 16'hFFFF) begin n_err++; $display("FAIL lost_saturate: got %04h, required ffff", lost_cnt); end
        hb  = 1'b1;
        clr = 1'b1;
        sb.push_back({2'd0, 8'h33});
        tick();
        n_cmp++; if (lost_cnt !== 16'h0) begin n_err++; $display("FAIL clear_priority: got %04h, required 0000", lost_cnt); end
        bus.seq_tvalid = 1'b0;
        sb.push_back({2'd1, 8'h7A});
        repeat (3) tick();
        test_sb_empty("stats");
    endtask

    task automatic test_disabled();
        do_reset();
        en = 4'b0111;
        bus.sw_tvalid = 1'b1; bus.sw_tdata = 8'h40;
        #1;
        n_cmp++; if (bus.sw_tready !== 1'b1) begin n_err++; $display("FAIL sw_disabled_tready: got %b, required 1", bus.sw_tready); end
        repeat (3) tick();
        en = 4'b1011;
        bus.seq_tvalid = 1'b1; bus.seq_tdata = 8'h12;
        bus.hw_tvalid  = 1'b1; bus.hw_tdata  = 8'h22;
        sb.push_back({2'd0, 8'h12});
        #1;
        n_cmp++; if (bus.hw_tready !== 1'b1) begin n_err++; $display("FAIL hw_disabled_tready: got %b, required 1", bus.hw_tready); end
        tick();
        en = 4'b1110;
        bus.seq_tdata = 8'h13;
        bus.hw_tvalid = 1'b1; bus.hw_tdata = 8'h23;
        sb.push_back({2'd2, 8'h23});
        #1;
        n_cmp++; if (bus.hw_tready !== 1'b1) begin n_err++; $display("FAIL seq_disabled_hw_tready: got %b, required 1", bus.hw_tready); end
        tick();
        bus.seq_tvalid = 1'b0;
        repeat (3) tick();
        test_sb_empty("disabled");
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 4'hF;
        bus.seq_tvalid = 1'b1; bus.seq_tdata = 8'h11;
        hb = 1'b1;
        sb.push_back({2'd0, 8'h11});
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.ev_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_valid: got %b, required 0", bus.ev_valid); end
        n_cmp++; if (bus.hw_tready !== 1'b0) begin n_err++; $display("FAIL mid_reset_tready: got %b, required 0", bus.hw_tready); end
        repeat (2) @(negedge clk);
        rst            = 1'b0;
        bus.seq_tvalid = 1'b0;
        repeat (6) tick();
        test_sb_empty("reset_mid");
    endtask

    initial begin
        test_reset();
        test_priority();
        test_heartbeat();
        test_round_robin();
        test_stats();
        test_disabled();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
